alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor to the 4-bit combinational ALU used by the tt_um top level. It provides a WIDTH-bit ALU with registered results and status flags. Operands are accepted over a valid/ready handshake. Eight opcodes are supported, including a multi-cycle shift-add multiply driven by a small state machine. It sits behind the tt_um pin mapping: operands come from ui_in/uio_in and the result and flags drive uo_out.

Parameters:
WIDTH, 8, operand/result width in bits; legal values 4..32.
SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous active-high reset.
en  input  1  global enable; when low, all state freezes, including the FSM, counters and output registers.
in_valid  input  1  operand/opcode qualifier.
in_ready  output  1  high when a new operation can be accepted.
opcode  input  3  operation select (see Behaviour).
in_1  input  WIDTH  operand A.
in_2  input  WIDTH  operand B.
out_valid  output  1  one-cycle pulse marking that out and flags are updated.
out  output  WIDTH  registered result.
flag_z  output  1  result == 0.
flag_c  output  1  carry/borrow/overflow-out (see per-op rules).
flag_n  output  1  out[WIDTH-1].
flag_v  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - Reset values: FSM=IDLE, in_ready=1, out_valid=0, out=0, all flags=0, multiply registers=0.
  - rst overrides en.
- Handshake:
  - An operation is accepted when in_valid && in_ready && en.
  - Operands and opcode are captured on acceptance.
- Opcodes:
  - 000 ADD: out = A+B; C = carry-out.
  - 001 SUB: out = A-B; C = borrow (A<B unsigned).
  - 010 AND, 011 OR, 100 XOR: C = 0.
  - 101 SHL: out = A << B[SHW-1:0]; C = last bit shifted out; C = 0 if the shift amount is 0.
  - 110 SHR (logical): mirror of SHL.
  - 111 MUL: unsigned; out = low WIDTH bits of A*B; C = 1 if any high-half bit is nonzero.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accepting a non-MUL op: compute and register out/flags; next state DONE; latency 1 cycle to out_valid.
  - IDLE, accepting MUL: load multiplicand, multiplier and a 2*WIDTH product register; counter=0; next state MUL; in_ready=0.
  - MUL: each cycle, if multiplier[0] then add the shifted multiplicand to the product. Shift the multiplier right and the multiplicand left; counter++.
  - MUL exit: after WIDTH iterations (counter == WIDTH-1 processed), register out/flags and go to DONE.
  - MUL latency: WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1 for exactly one cycle; in_ready=1, so back-to-back accept is allowed; next state IDLE, or DONE/MUL on a new accept.
- in_ready: low only in MUL.
- Holding: out and flags hold their last value until the next completion.
- en low mid-MUL: iteration pauses and resumes when en returns high; the result is identical. out_valid is not asserted while en is low; it is deferred to the next enabled cycle.
- rst mid-MUL: the operation is discarded, with no out_valid.
- Invalid: in_valid while in_ready=0 is ignored; no queueing.
- No output back-pressure: the consumer must sample out on out_valid.

Optional Feature:
ALU_SAT_EN:
- Defined: ADD and SUB saturate.
  - Unsigned ADD overflow gives all-ones.
  - SUB borrow gives 0.
  - C still reports that saturation occurred.
  - MUL with a nonzero high half gives all-ones.
- Undefined: wrap-around results as above.
- Flag semantics are unchanged except that out reflects the saturated value; flag_z and flag_n are computed from the saturated out.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - FSM state typedef/localparams ST_IDLE, ST_MUL, ST_DONE;
  - a flags struct or bit-index constants FLG_Z, FLG_C, FLG_N, FLG_V.
- One natural sub-module: alu_mul_seq, the shift-add multiplier datapath with start/busy/done and a WIDTH parameter.
- Combinational ops remain in alu_seq.

Test Plan:
- WIDTH=8, reset then ADD 0xF0+0x20: out=0x10, C=1, Z=0, V=0, out_valid 1 cycle after accept.
- SUB 0x80-0x01: out=0x7F, C=0, V=1, N=0; SUB 0x05-0x05: out=0x00, Z=1.
- MUL 0x0F*0x11: out=0xFF, C=0, out_valid at accept+9; in_ready=0 for 8 cycles. MUL 0x10*0x10: out=0x00, C=1 (ALU_SAT_EN: out=0xFF).
- SHL 0x81 by 1: out=0x02, C=1; SHR 0x81 by 0: out=0x81, C=0. Back-to-back accepts on consecutive cycles give consecutive out_valid pulses.
- MUL 0xFF*0xFF with en low for 3 cycles mid-operation: out=0x01, C=1, out_valid delayed exactly 3 cycles.
- rst asserted at MUL cycle 4: no out_valid, out=0, in_ready=1 the next cycle; in_valid during MUL is ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state codes and flag bit positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    function automatic logic [3:0] make_flags(input logic z, input logic c,
                                              input logic n, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial-product step per enabled cycle, WIDTH steps total.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_prod_next;

    // o_product already includes the current step, so the final value is usable in the done cycle.
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign o_done      = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_busy      = r_busy;
    assign o_product   = w_prod_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (o_done) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with registered result/flags, valid/ready operand intake and a sequential multiply.
// Build option: define ALU_SAT_EN to make ADD, SUB and MUL saturate instead of wrapping.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic [1:0]       o_dbg_state
);

    // Handshake: an operation is taken on a rising edge where in_valid, in_ready and en are all high;
    // in_ready drops only while a multiply is iterating, and out_valid marks the one enabled DONE cycle.

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic [3:0]         r_flags;

    logic               w_accept;
    logic               w_in_mul;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic               w_mul_hi_nz;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;
    logic               w_load;
    logic [WIDTH-1:0]   w_ld_res;
    logic               w_ld_c;
    logic               w_ld_v;
    logic [3:0]         w_ld_flags;

    assign in_ready    = ~w_mul_busy;
    assign w_in_mul    = (r_state == ST_MUL);
    assign w_accept    = in_valid && in_ready && en;
    assign w_mul_start = w_accept && (opcode == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_start   (w_mul_start),
        .i_a       (in_1),
        .i_b       (in_2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign w_add   = {1'b0, in_1} + {1'b0, in_2};
    assign w_sub   = {1'b0, in_1} - {1'b0, in_2};
    assign w_shamt = in_2[SHW-1:0];
    // The extra bit on each shift catches the last bit pushed out, which becomes the carry.
    assign w_shl   = {1'b0, in_1} << w_shamt;
    assign w_shr   = {in_1, 1'b0} >> w_shamt;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (w_add[WIDTH-1] != in_1[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (w_add[WIDTH]) w_alu_res = '1;
`endif
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (w_sub[WIDTH-1] != in_1[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (w_sub[WIDTH]) w_alu_res = '0;
`endif
            end
            OP_AND: w_alu_res = in_1 & in_2;
            OP_OR:  w_alu_res = in_1 | in_2;
            OP_XOR: w_alu_res = in_1 ^ in_2;
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                w_alu_c   = w_shr[0];
            end
            default: ;
        endcase
    end

    assign w_mul_hi_nz = |w_mul_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SAT_EN
    assign w_mul_res = w_mul_hi_nz ? {WIDTH{1'b1}} : w_mul_prod[WIDTH-1:0];
`else
    assign w_mul_res = w_mul_prod[WIDTH-1:0];
`endif

    assign w_load     = w_in_mul ? w_mul_done : (w_accept && (opcode != OP_MUL));
    assign w_ld_res   = w_in_mul ? w_mul_res : w_alu_res;
    assign w_ld_c     = w_in_mul ? w_mul_hi_nz : w_alu_c;
    assign w_ld_v     = w_in_mul ? 1'b0 : w_alu_v;
    assign w_ld_flags = make_flags(w_ld_res == '0, w_ld_c, w_ld_res[WIDTH-1], w_ld_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_flags <= '0;
        end else if (en) begin
            if (w_load) begin
                r_out   <= w_ld_res;
                r_flags <= w_ld_flags;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state <= (opcode == OP_MUL) ? ST_MUL : ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A DONE state held through an en-low stretch reports its pulse on the first enabled cycle.
    assign out_valid   = (r_state == ST_DONE) && en;
    assign out         = r_out;
    assign flag_z      = r_flags[FLG_Z];
    assign flag_c      = r_flags[FLG_C];
    assign flag_n      = r_flags[FLG_N];
    assign flag_v      = r_flags[FLG_V];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model (WIDTH=8).
module tb_alu_seq;

    localparam int     W  = 8;
    localparam int     EW = W + 4;
    localparam longint M  = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] in_1, in_2, out;
    logic         out_valid, flag_z, flag_c, flag_n, flag_v;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out(out),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / model ----------------
    function automatic logic [EW-1:0] pk(input logic v, input logic n, input logic c,
                                         input logic z, input logic [W-1:0] o);
        return {v, n, c, z, o};
    endfunction

    function automatic logic [EW-1:0] obs_now();
        return {flag_v, flag_n, flag_c, flag_z, out};
    endfunction

    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a_in,
                                            input logic [W-1:0] b_in);
        longint a, b, r, sa, sb, sr;
        int s;
        logic c, v;
        a  = longint'(a_in);
        b  = longint'(b_in);
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        s  = int'(b % (64'd1 << $clog2(W)));
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        case (op)
            3'd0: begin
                r  = a + b;
                c  = (r >= M);
                sr = sa + sb;
                v  = (sr >= M / 2) || (sr < -(M / 2));
                r  = r % M;
`ifdef ALU_SAT_EN
                if (c) r = M - 1;
`endif
            end
            3'd1: begin
                c  = (a < b);
                sr = sa - sb;
                v  = (sr >= M / 2) || (sr < -(M / 2));
                r  = (a - b + M) % M;
`ifdef ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a << s;
                c = (s != 0) && (((r / M) % 2) == 1);
                r = r % M;
            end
            3'd6: begin
                c = (s != 0) && (((a >> (s - 1)) % 2) == 1);
                r = a >> s;
            end
            default: begin
                r = a * b;
                c = (r >= M);
                r = r % M;
`ifdef ALU_SAT_EN
                if (c) r = M - 1;
`endif
            end
        endcase
        return pk(v, r >= M / 2, c, r == 0, W'(r));
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Issues one operation from the current negedge, returns the observed result, the
    // accept-to-out_valid latency in cycles and the number of cycles in_ready was low.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pause_at, input int pause_len, input bit poke,
                          output logic [EW-1:0] res, output int lat, output int busy_cyc);
        in_valid = 1'b1;
        opcode   = op;
        in_1     = a;
        in_2     = b;
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 3'($urandom);
        in_1     = W'($urandom);
        in_2     = W'($urandom);
        lat      = 1;
        busy_cyc = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready === 1'b0) busy_cyc++;
            if (lat == pause_at) en = 1'b0;
            if (lat == pause_at + pause_len) en = 1'b1;
            in_valid = poke && (lat == 2);
            @(negedge clk);
            lat++;
        end
        en       = 1'b1;
        in_valid = 1'b0;
        res      = obs_now();
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int pause_at, input int pause_len,
                            input bit poke, output logic [EW-1:0] res);
        logic [EW-1:0] e;
        int lat, busy_cyc, plen;
        plen = (op == 3'd7) ? pause_len : 0;
        run_op(op, a, b, pause_at, plen, poke, res, lat, busy_cyc);
        e = model(op, a, b);
        chk({tag, "_res"}, 32'(res), 32'(e));
        chk({tag, "_lat"}, lat, (op == 3'd7) ? (W + 1 + plen) : 1);
        chk({tag, "_rdy_low"}, busy_cyc, (op == 3'd7) ? (W + plen) : 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(out_valid), 0);
        chk({tag, "_hold"}, 32'(obs_now()), 32'(e));
    endtask

    // Drives n non-multiply operations on consecutive cycles; ends on the negedge of the last pulse.
    task automatic b2b(input int n);
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            op       = 3'($urandom_range(0, 6));
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = 1'b1;
            opcode   = op;
            in_1     = a;
            in_2     = b;
            exp_q.push_back(model(op, a, b));
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 1);
            chk("b2b_res", 32'(obs_now()), 32'(exp_q.pop_front()));
        end
        in_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [EW-1:0] r;
        logic [2:0]    op;
        int            seen;

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; opcode = '0; in_1 = '0; in_2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_outflags", 32'(obs_now()), 0);
        chk("rst_state", 32'(dbg_state), 32'(alu_pkg::ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

`ifdef ALU_SAT_EN
        op_check("add_f0_20", 3'd0, 8'hF0, 8'h20, 0, 0, 1'b0, r);
        chk("add_f0_20_const", 32'(r), 32'(pk(0, 1, 1, 0, 8'hFF)));
`else
        op_check("add_f0_20", 3'd0, 8'hF0, 8'h20, 0, 0, 1'b0, r);
        chk("add_f0_20_const", 32'(r), 32'(pk(0, 0, 1, 0, 8'h10)));
`endif
        op_check("sub_80_01", 3'd1, 8'h80, 8'h01, 0, 0, 1'b0, r);
        chk("sub_80_01_const", 32'(r), 32'(pk(1, 0, 0, 0, 8'h7F)));
        op_check("sub_05_05", 3'd1, 8'h05, 8'h05, 0, 0, 1'b0, r);
        chk("sub_05_05_const", 32'(r), 32'(pk(0, 0, 0, 1, 8'h00)));
        op_check("mul_0f_11", 3'd7, 8'h0F, 8'h11, 0, 0, 1'b0, r);
        chk("mul_0f_11_const", 32'(r), 32'(pk(0, 1, 0, 0, 8'hFF)));
        op_check("mul_10_10", 3'd7, 8'h10, 8'h10, 0, 0, 1'b0, r);
`ifdef ALU_SAT_EN
        chk("mul_10_10_const", 32'(r), 32'(pk(0, 1, 1, 0, 8'hFF)));
`else
        chk("mul_10_10_const", 32'(r), 32'(pk(0, 0, 1, 1, 8'h00)));
`endif
        op_check("shl_81_1", 3'd5, 8'h81, 8'h01, 0, 0, 1'b0, r);
        chk("shl_81_1_const", 32'(r), 32'(pk(0, 0, 1, 0, 8'h02)));
        op_check("shr_81_0", 3'd6, 8'h81, 8'h00, 0, 0, 1'b0, r);
        chk("shr_81_0_const", 32'(r), 32'(pk(0, 1, 0, 0, 8'h81)));

        // Multiply with en dropped for 3 cycles starting at iteration cycle 3.
        op_check("mul_ff_ff_pause", 3'd7, 8'hFF, 8'hFF, 3, 3, 1'b0, r);
`ifdef ALU_SAT_EN
        chk("mul_ff_ff_const", 32'(r), 32'(pk(0, 1, 1, 0, 8'hFF)));
`else
        chk("mul_ff_ff_const", 32'(r), 32'(pk(0, 0, 1, 0, 8'h01)));
`endif
        // in_valid raised while the multiply is busy must be ignored.
        op_check("mul_poke", 3'd7, 8'h35, 8'h0B, 0, 0, 1'b1, r);

        // Consecutive accepts, then a multiply accepted straight out of the last pulse cycle.
        b2b(12);
        op_check("mul_from_done", 3'd7, 8'hA7, 8'h3C, 0, 0, 1'b0, r);

        // Reset in the fourth multiply cycle discards the operation.
        in_valid = 1'b1; opcode = 3'd7; in_1 = 8'hC3; in_2 = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmul_valid", 32'(out_valid), 0);
        chk("rstmul_out", 32'(obs_now()), 0);
        chk("rstmul_ready", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("rstmul_no_valid", seen, 0);

        // Randomized operations, multiplies sometimes paused or poked.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            op_check("rand", op, W'($urandom), W'($urandom), $urandom_range(1, W),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
